// File: rtl/bitbakery_serial_rx_pkg.sv
// Shared packet framing constants and state encodings for the bitbakery serial link.
// The transmitter uses the same header, trailer and payload length.
package bitbakery_serial_rx_pkg;

    localparam logic [7:0] PKT_HEADER      = 8'hFF;
    localparam logic [7:0] PKT_TRAILER     = 8'hFE;
    localparam int         PKT_PAYLOAD_LEN = 11;

    typedef enum logic [1:0] {
        ESPERA_CAB = 2'd0,
        RECEBE     = 2'd1,
        ESPERA_FIM = 2'd2
    } pkt_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/rx_serial_8E1.sv
// Byte receiver for an 8E1 serial line: 2-FF synchroniser, start-bit glitch filter,
// mid-bit sampling driven by a down-counter, even-parity and stop-bit checks.
//
// state        | meaning
// RX_IDLE      | line idle, watching for a high-to-low edge
// RX_START     | waiting for start-bit midpoint to confirm it is still low
// RX_DATA      | sampling 8 data bits, LSB first
// RX_PARITY    | sampling the parity bit
// RX_STOP      | sampling the stop bit and reporting the result
// RX_WAIT_HIGH | framing error seen, waiting for the line to return high
module rx_serial_8E1
    import bitbakery_serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial,
    output logic [7:0] dados,
    output logic       pronto,
    output logic       erro_paridade,
    output logic       erro_parada
);

    localparam int              TW      = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0]   FULL_TC = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]   HALF_TC = TW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     state, state_next;
    logic [1:0]    sync;
    logic          line, line_prev;
    logic [TW-1:0] timer;
    logic          tick;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;

    assign line = sync[1];
    assign tick = (timer == '0);

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:      if (line_prev && !line) state_next = RX_START;
            RX_START:     if (tick) state_next = line ? RX_IDLE : RX_DATA;
            RX_DATA:      if (tick && bit_idx == 3'd7) state_next = RX_PARITY;
            RX_PARITY:    if (tick) state_next = RX_STOP;
            RX_STOP:      if (tick) state_next = line ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (line) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    // Synchroniser resets low so only a genuine high-to-low transition after reset starts a byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= RX_IDLE;
            sync          <= 2'b00;
            line_prev     <= 1'b0;
            timer         <= '0;
            bit_idx       <= 3'd0;
            shift         <= 8'h00;
            par_bit       <= 1'b0;
            dados         <= 8'h00;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_parada   <= 1'b0;
        end else begin
            sync          <= {sync[0], serial};
            line_prev     <= line;
            state         <= state_next;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_parada   <= 1'b0;
            if (!tick) timer <= timer - 1'b1;
            case (state)
                RX_IDLE: if (line_prev && !line) timer <= HALF_TC;
                RX_START: if (tick) begin
                    timer   <= FULL_TC;
                    bit_idx <= 3'd0;
                end
                RX_DATA: if (tick) begin
                    shift   <= {line, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                    timer   <= FULL_TC;
                end
                RX_PARITY: if (tick) begin
                    par_bit <= line;
                    timer   <= FULL_TC;
                end
                RX_STOP: if (tick) begin
                    if (!line) begin
                        erro_parada <= 1'b1;
                    end else if (^{shift, par_bit}) begin
                        erro_paridade <= 1'b1;
                    end else begin
                        pronto <= 1'b1;
                        dados  <= shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bitbakery_serial_rx.sv
// Packet receiver: frames FF + 11 payload bytes + FE from the byte receiver and commits
// the payload to the output registers only when the trailer arrives intact.
//
// state      | meaning
// ESPERA_CAB | hunting for the 0xFF header
// RECEBE     | storing payload bytes into the shadow register
// ESPERA_FIM | expecting the 0xFE trailer to commit the shadow
module bitbakery_serial_rx
    import bitbakery_serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [7:0]  D0,
    output logic [7:0]  D1,
    output logic [7:0]  D2,
    output logic [63:0] map_obstacles,
    output logic        pacote_valido,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic [3:0]  db_estado
);

    pkt_state_t  state, state_next;
    logic [7:0]  rx_dados;
    logic        rx_pronto, rx_erro_paridade, rx_erro_parada;
    logic        byte_err;
    logic        commit, trailer_bad;
    logic [3:0]  idx;
    logic [87:0] shadow;

    rx_serial_8E1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock         (clock),
        .reset         (reset),
        .serial        (entrada_serial),
        .dados         (rx_dados),
        .pronto        (rx_pronto),
        .erro_paridade (rx_erro_paridade),
        .erro_parada   (rx_erro_parada)
    );

    assign byte_err  = rx_erro_paridade | rx_erro_parada;
    assign db_estado = {2'b00, state};

    always_comb begin
        state_next  = state;
        commit      = 1'b0;
        trailer_bad = 1'b0;
        case (state)
            ESPERA_CAB: if (rx_pronto && rx_dados == PKT_HEADER) state_next = RECEBE;
            RECEBE: begin
                if (byte_err) state_next = ESPERA_CAB;
                else if (rx_pronto && idx == 4'(PKT_PAYLOAD_LEN - 1)) state_next = ESPERA_FIM;
            end
            ESPERA_FIM: begin
                if (byte_err) begin
                    state_next = ESPERA_CAB;
                end else if (rx_pronto) begin
                    state_next = ESPERA_CAB;
                    if (rx_dados == PKT_TRAILER) commit = 1'b1;
                    else trailer_bad = 1'b1;
                end
            end
            default: state_next = ESPERA_CAB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ESPERA_CAB;
            idx           <= 4'd0;
            shadow        <= '0;
            D0            <= 8'h00;
            D1            <= 8'h00;
            D2            <= 8'h00;
            map_obstacles <= 64'h0;
            pacote_valido <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
        end else begin
            state         <= state_next;
            pacote_valido <= commit;
            erro_paridade <= rx_erro_paridade;
            erro_quadro   <= rx_erro_parada | trailer_bad;
            if (state == ESPERA_CAB) idx <= 4'd0;
            if (state == RECEBE && rx_pronto) begin
                shadow[{idx, 3'b000} +: 8] <= rx_dados;
                idx <= idx + 4'd1;
            end
            if (commit) begin
                D0            <= shadow[7:0];
                D1            <= shadow[15:8];
                D2            <= shadow[23:16];
                map_obstacles <= shadow[87:24];
            end
        end
    end

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// Directed bench for bitbakery_serial_rx at 16 clocks per bit: good, corrupted,
// garbage-prefixed, glitched and reset-interrupted packets.
module tb_bitbakery_serial_rx;

    localparam int CPB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        entrada_serial = 1'b1;
    logic [7:0]  D0, D1, D2;
    logic [63:0] map_obstacles;
    logic        pacote_valido, erro_paridade, erro_quadro;
    logic [3:0]  db_estado;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_perr = 0;
    int n_ferr = 0;

    bitbakery_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .D0             (D0),
        .D1             (D1),
        .D2             (D2),
        .map_obstacles  (map_obstacles),
        .pacote_valido  (pacote_valido),
        .erro_paridade  (erro_paridade),
        .erro_quadro    (erro_quadro),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (pacote_valido) n_valid++;
        if (erro_paridade) n_perr++;
        if (erro_quadro)   n_ferr++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_perr  = 0;
        n_ferr  = 0;
    endtask

    task automatic hold_bit(input logic v);
        entrada_serial = v;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit((^b) ^ bad_par);
        hold_bit(~bad_stop);
        hold_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [87:0] pl,
                              input logic [7:0] trl, input int bad_idx);
        send_byte(hdr, 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) send_byte(pl[8*k +: 8], (k == bad_idx), 1'b0);
        send_byte(trl, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        entrada_serial = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(4);

        chk("rst_d0", {56'h0, D0}, 64'h00);
        chk("rst_d1", {56'h0, D1}, 64'h00);
        chk("rst_d2", {56'h0, D2}, 64'h00);
        chk("rst_map", map_obstacles, 64'h0);
        chk("rst_pulses", {61'h0, pacote_valido, erro_paridade, erro_quadro}, 64'h0);
        chk("rst_state", {60'h0, db_estado}, 64'h0);

        // Basic packet
        clear_counts();
        send_frame(8'hFF, 88'h8877665544332211030201, 8'hFE, -1);
        idle(8);
        chk("p1_d0", {56'h0, D0}, 64'h01);
        chk("p1_d1", {56'h0, D1}, 64'h02);
        chk("p1_d2", {56'h0, D2}, 64'h03);
        chk("p1_map", map_obstacles, 64'h8877665544332211);
        chk("p1_valid_cnt", 64'(n_valid), 64'd1);
        chk("p1_err_cnt", 64'(n_perr + n_ferr), 64'd0);
        chk("p1_state", {60'h0, db_estado}, 64'h0);

        // Parity error on the fifth byte of the frame
        clear_counts();
        send_frame(8'hFF, 88'h8877665544332211030201, 8'hFE, 3);
        idle(8);
        chk("par_perr_cnt", 64'(n_perr), 64'd1);
        chk("par_valid_cnt", 64'(n_valid), 64'd0);
        chk("par_map_hold", map_obstacles, 64'h8877665544332211);
        chk("par_d0_hold", {56'h0, D0}, 64'h01);

        // Following good packet, with 0xFE as legal payload data
        clear_counts();
        send_frame(8'hFF, 88'h0807060504030201A3FEA1, 8'hFE, -1);
        idle(8);
        chk("p2_d0", {56'h0, D0}, 64'hA1);
        chk("p2_d1", {56'h0, D1}, 64'hFE);
        chk("p2_d2", {56'h0, D2}, 64'hA3);
        chk("p2_map", map_obstacles, 64'h0807060504030201);
        chk("p2_valid_cnt", 64'(n_valid), 64'd1);

        // Bad trailer
        clear_counts();
        send_frame(8'hFF, 88'h1111111111111111111111, 8'h00, -1);
        idle(8);
        chk("trl_ferr_cnt", 64'(n_ferr), 64'd1);
        chk("trl_valid_cnt", 64'(n_valid), 64'd0);
        chk("trl_map_hold", map_obstacles, 64'h0807060504030201);
        chk("trl_d1_hold", {56'h0, D1}, 64'hFE);
        chk("trl_state", {60'h0, db_estado}, 64'h0);

        // Stop bit low
        clear_counts();
        send_byte(8'h5A, 1'b0, 1'b1);
        idle(8);
        chk("stop_ferr_cnt", 64'(n_ferr), 64'd1);
        chk("stop_perr_cnt", 64'(n_perr), 64'd0);

        // Garbage then an all-0xFF payload
        clear_counts();
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_frame(8'hFF, {11{8'hFF}}, 8'hFE, -1);
        idle(8);
        chk("ff_map", map_obstacles, 64'hFFFFFFFFFFFFFFFF);
        chk("ff_d012", {40'h0, D0, D1, D2}, 64'hFFFFFF);
        chk("ff_valid_cnt", 64'(n_valid), 64'd1);
        chk("ff_err_cnt", 64'(n_perr + n_ferr), 64'd0);

        // Short low glitch right after a header must not count as a byte
        clear_counts();
        send_byte(8'hFF, 1'b0, 1'b0);
        entrada_serial = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        idle(3 * CPB);
        chk("glitch_state", {60'h0, db_estado}, 64'h1);
        chk("glitch_err_cnt", 64'(n_perr + n_ferr), 64'd0);
        for (int k = 0; k < 11; k++) begin
            logic [87:0] gp;
            gp = 88'hD8D7D6D5D4D3D2D1C3C2C1;
            send_byte(gp[8*k +: 8], 1'b0, 1'b0);
        end
        send_byte(8'hFE, 1'b0, 1'b0);
        idle(8);
        chk("glitch_map", map_obstacles, 64'hD8D7D6D5D4D3D2D1);
        chk("glitch_d0", {56'h0, D0}, 64'hC1);
        chk("glitch_valid_cnt", 64'(n_valid), 64'd1);

        // Reset after six bytes
        send_byte(8'hFF, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        chk("mid_state", {60'h0, db_estado}, 64'h1);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(4);
        chk("rst2_map", map_obstacles, 64'h0);
        chk("rst2_d012", {40'h0, D0, D1, D2}, 64'h0);
        chk("rst2_state", {60'h0, db_estado}, 64'h0);
        clear_counts();
        send_frame(8'hFF, 88'h8877665544332211030201, 8'hFE, -1);
        idle(8);
        chk("rst2_map_after", map_obstacles, 64'h8877665544332211);
        chk("rst2_d012_after", {40'h0, D0, D1, D2}, 64'h010203);
        chk("rst2_valid_cnt", 64'(n_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
